// File: rtl/program_fetch.sv
// Program fetch unit: PC, one-stage instruction register, flow-change decode and a
// circular return-address stack. Define PROGRAM_FETCH_STACK_GUARD_EN for the sticky stack_err flag.
module program_fetch #(
  parameter logic [10:0] RESET_VECTOR = 11'h000,
  parameter int          STACK_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] rom_addr_out,
  input  logic [13:0] rom_data_in,
  input  logic        stall,
  input  logic        skip_req,
  output logic [13:0] ir_out,
  output logic        ir_valid,
  output logic [10:0] pc_out,
  output logic        stack_err
);

  // STACK_DEPTH is a power of two (>= 2), so the pointer wraps naturally.
  localparam int              SP_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

  logic [10:0]     r_pc;
  logic [13:0]     r_ir;
  logic            r_ir_valid;
  logic [10:0]     r_pc_out;
  logic [SP_W-1:0] r_sp;
  logic [10:0]     r_stack [STACK_DEPTH];

  logic            w_is_goto;
  logic            w_is_call;
  logic            w_is_ret;
  logic            w_flow;
  logic            w_skip;
  logic [SP_W-1:0] w_sp_dec;
  logic [10:0]     w_pop_addr;
  logic [10:0]     w_ret_addr;
  logic [10:0]     w_pc_next;

  // A bubble in the IR never decodes as anything.
  assign w_is_goto  = r_ir_valid && (r_ir[13:11] == 3'b101);
  assign w_is_call  = r_ir_valid && (r_ir[13:11] == 3'b100);
  assign w_is_ret   = r_ir_valid && ((r_ir == 14'h0008) || (r_ir[13:10] == 4'b1101));
  assign w_flow     = w_is_goto || w_is_call || w_is_ret;
  assign w_skip     = r_ir_valid && skip_req && !w_flow;
  assign w_sp_dec   = r_sp - SP_ONE;
  assign w_pop_addr = r_stack[w_sp_dec];
  assign w_ret_addr = r_pc_out + 11'd1;

  always_comb begin
    w_pc_next = r_pc + 11'd1;
    if (w_is_goto || w_is_call) begin
      w_pc_next = r_ir[10:0];
    end else if (w_is_ret) begin
      w_pc_next = w_pop_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_VECTOR;
      r_ir       <= 14'h0000;
      r_ir_valid <= 1'b0;
      r_pc_out   <= 11'h000;
      r_sp       <= '0;
    end else if (!stall) begin
      r_pc       <= w_pc_next;
      r_ir       <= rom_data_in;
      r_pc_out   <= r_pc;
      // The word fetched alongside a flow change or skip is discarded.
      r_ir_valid <= !(w_flow || w_skip);
      if (w_is_call) begin
        r_sp <= r_sp + SP_ONE;
      end else if (w_is_ret) begin
        r_sp <= w_sp_dec;
      end
    end
  end

  // Stack contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && !stall && w_is_call) begin
      r_stack[r_sp] <= w_ret_addr;
    end
  end

`ifdef PROGRAM_FETCH_STACK_GUARD_EN
  localparam int               DEPTH_W   = $clog2(STACK_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  logic [DEPTH_W-1:0] r_depth;
  logic               r_stack_err;

  // Depth saturates; the stack itself keeps wrapping regardless.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_depth     <= '0;
      r_stack_err <= 1'b0;
    end else if (!stall) begin
      if (w_is_call) begin
        if (r_depth == DEPTH_MAX) begin
          r_stack_err <= 1'b1;
        end else begin
          r_depth <= r_depth + DEPTH_W'(1);
        end
      end else if (w_is_ret) begin
        if (r_depth == '0) begin
          r_stack_err <= 1'b1;
        end else begin
          r_depth <= r_depth - DEPTH_W'(1);
        end
      end
    end
  end

  assign stack_err = r_stack_err;
`else
  assign stack_err = 1'b0;
`endif

  assign rom_addr_out = r_pc;
  assign ir_out       = r_ir;
  assign ir_valid     = r_ir_valid;
  assign pc_out       = r_pc_out;

endmodule

// File: tb/tb_program_fetch.sv
// Directed bench for program_fetch: reset vector, sequential run with skip/stall/GOTO,
// CALL/RETURN/RETLW, and nine nested CALLs around the stack wrap.
module tb_program_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, skip_req;
  logic [10:0] rom_addr, rom_addr2, pc_out, pc_out2;
  logic [13:0] rom_data, rom_data2, ir_out, ir_out2;
  logic        ir_valid, ir_valid2, stack_err, stack_err2;
  logic [13:0] rom [0:2047];

  assign rom_data  = rom[rom_addr];
  assign rom_data2 = rom[rom_addr2];

  program_fetch dut (
    .clk(clk), .reset(reset), .rom_addr_out(rom_addr), .rom_data_in(rom_data),
    .stall(stall), .skip_req(skip_req), .ir_out(ir_out), .ir_valid(ir_valid),
    .pc_out(pc_out), .stack_err(stack_err)
  );

  program_fetch #(.RESET_VECTOR(11'h7FE)) dut_rv (
    .clk(clk), .reset(reset), .rom_addr_out(rom_addr2), .rom_data_in(rom_data2),
    .stall(1'b0), .skip_req(1'b0), .ir_out(ir_out2), .ir_valid(ir_valid2),
    .pc_out(pc_out2), .stack_err(stack_err2)
  );

`ifdef PROGRAM_FETCH_STACK_GUARD_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct packed {
    logic        stall;
    logic        skip;
    logic        exp_valid;
    logic [10:0] exp_pc;
    logic [13:0] exp_ir;
    logic [10:0] exp_addr;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
  endtask

  task automatic add(input logic s, input logic k, input logic v, input logic [10:0] p,
                     input logic [13:0] ir, input logic [10:0] a);
    vecs.push_back('{stall: s, skip: k, exp_valid: v, exp_pc: p, exp_ir: ir, exp_addr: a});
  endtask

  // CALL 5 at 0x000, return-type word at 0x005, NOPs elsewhere.
  task automatic run_call(input logic [13:0] ret_word, input string tag);
    int          exp_pc [6]   = '{0, 1, 5, 6, 1, 2};
    logic        exp_v  [6]   = '{1, 0, 1, 0, 1, 1};
    int          exp_a  [6]   = '{1, 5, 6, 1, 2, 3};
    clear_rom();
    rom[0] = 14'h2005;
    rom[5] = ret_word;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("%s_pc%0d", tag, i), pc_out, exp_pc[i]);
      chk($sformatf("%s_valid%0d", tag, i), ir_valid, exp_v[i]);
      chk($sformatf("%s_addr%0d", tag, i), rom_addr, exp_a[i]);
      $display("%s slot %0d: pc_out=%03h ir=%04h valid=%0b", tag, i, pc_out, ir_out, ir_valid);
    end
    chk({tag, "_err"}, stack_err, 0);
  endtask

  initial begin
    int exp_seq [18] = '{0, 2, 4, 6, 8, 10, 12, 14, 16, 18, 17, 15, 13, 11, 9, 7, 5, 3};
    int got [$];
    int budget;

    reset = 1'b1; stall = 1'b0; skip_req = 1'b0;
    clear_rom();
    tick(); tick();
    chk("rst_valid", ir_valid, 0);
    chk("rst_ir", ir_out, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_err", stack_err, 0);
    chk("rv_rst_addr", rom_addr2, 11'h7FE);
    chk("rv_rst_pc_out", pc_out2, 0);
    reset = 1'b0;
    tick(); chk("rv_pc0", pc_out2, 11'h7FE); chk("rv_v0", ir_valid2, 1);
    tick(); chk("rv_pc1", pc_out2, 11'h7FF);
    tick(); chk("rv_pc2", pc_out2, 11'h000); chk("rv_v2", ir_valid2, 1);
    $display("reset vector run: pc_out=%03h valid=%0b", pc_out2, ir_valid2);

    // Sequential program ending in GOTO 0.
    clear_rom();
    rom[0] = 14'h3000; rom[1] = 14'h008D; rom[2] = 14'h3000; rom[3] = 14'h008D;
    rom[4] = 14'h3009; rom[5] = 14'h008D;
    for (int i = 6; i < 16; i++) rom[i] = 14'h3000 | 14'(i);
    rom[16] = 14'h2800;
    rom[17] = 14'h0123;

    // Reset applied while stalled still takes effect.
    reset = 1'b1; stall = 1'b1; tick();
    chk("rst_stall_valid", ir_valid, 0);
    chk("rst_stall_pc_out", pc_out, 0);
    chk("rst_stall_addr", rom_addr, 0);
    reset = 1'b0; stall = 1'b0;

    add(0, 0, 1, 0, 14'h3000, 1);
    add(0, 0, 1, 1, 14'h008D, 2);
    add(0, 0, 1, 2, 14'h3000, 3);
    add(0, 0, 1, 3, 14'h008D, 4);
    add(0, 1, 0, 4, 14'h3009, 5);
    add(0, 0, 1, 5, 14'h008D, 6);
    add(0, 0, 1, 6, 14'h3006, 7);
    add(1, 0, 1, 6, 14'h3006, 7);
    add(1, 1, 1, 6, 14'h3006, 7);
    add(1, 0, 1, 6, 14'h3006, 7);
    for (int p = 7; p < 16; p++) add(0, 0, 1, 11'(p), 14'h3000 | 14'(p), 11'(p + 1));
    add(0, 0, 1, 11'h010, 14'h2800, 11'h011);
    add(0, 1, 0, 11'h011, 14'h0123, 11'h000);
    add(0, 1, 1, 11'h000, 14'h3000, 11'h001);

    for (int i = 0; i < vecs.size(); i++) begin
      stall    = vecs[i].stall;
      skip_req = vecs[i].skip;
      tick();
      chk($sformatf("vec%0d_valid", i), ir_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_pc", i), pc_out, vecs[i].exp_pc);
      chk($sformatf("vec%0d_ir", i), ir_out, vecs[i].exp_ir);
      chk($sformatf("vec%0d_addr", i), rom_addr, vecs[i].exp_addr);
      $display("vec %0d: stall=%0b skip=%0b pc_out=%03h ir=%04h valid=%0b addr=%03h",
               i, stall, skip_req, pc_out, ir_out, ir_valid, rom_addr);
    end
    stall = 1'b0; skip_req = 1'b0;

    run_call(14'h0008, "call_ret");
    run_call(14'h3412, "call_retlw");

    // Nine nested CALLs: call site 2i calls 2i+2, RETURN at every odd address and at 0x12.
    clear_rom();
    for (int i = 0; i < 9; i++) begin
      rom[2 * i]     = 14'h2000 | 14'(2 * i + 2);
      rom[2 * i + 1] = 14'h0008;
    end
    rom[18] = 14'h0008;
    reset = 1'b1; tick(); reset = 1'b0;
    budget = 0;
    while (got.size() < 18 && budget < 80) begin
      tick();
      budget++;
      if (ir_valid) begin
        got.push_back(int'(pc_out));
        $display("nest slot: pc_out=%03h ir=%04h err=%0b", pc_out, ir_out, stack_err);
        if (pc_out == 11'd16) begin
          chk("nest_err_before9", stack_err, 0);
          tick();
          budget++;
          chk("nest_err_after9", stack_err, EXP_ERR);
        end
      end
    end
    chk("nest_budget", got.size(), 18);
    for (int i = 0; i < 18 && i < got.size(); i++) begin
      chk($sformatf("nest_seq%0d", i), got[i], exp_seq[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_fetch.md
PROGRAM_FETCH -- requirements
Module: program_fetch

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 11'h000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter STACK_DEPTH, default 8, meaning the number of return-address stack entries (power of two).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port rom_addr_out, output, 11 bits: address to the program ROM, driven directly from the PC register.
REQ-006 The block SHALL have port rom_data_in, input, 14 bits: combinational ROM data for rom_addr_out.
REQ-007 The block SHALL have port stall, input, 1 bit: hold all fetch state this cycle.
REQ-008 The block SHALL have port skip_req, input, 1 bit: execute requests that the next fetched instruction be discarded.
REQ-009 The block SHALL have port ir_out, output, 14 bits: instruction register.
REQ-010 The block SHALL have port ir_valid, output, 1 bit: ir_out is to be executed (0 = bubble, treat as NOP).
REQ-011 The block SHALL have port pc_out, output, 11 bits: address from which ir_out was fetched.
REQ-012 The block SHALL have port stack_err, output, 1 bit: sticky stack overflow/underflow flag.

Function
REQ-013 In each cycle with stall=0 the block SHALL update ir_out<=rom_data_in, pc_out<=PC and ir_valid<=1 (unless flushed), and SHALL advance PC<=PC+1 modulo 2048 (0x7FF wraps to 0x000).
REQ-014 Fetch latency SHALL be one clock: the word at address A SHALL appear on ir_out on the edge after PC==A.
REQ-015 Decode of ir_out SHALL apply only when ir_valid=1, using GOTO = ir[13:11]==3'b101, CALL = ir[13:11]==3'b100, RETURN = 14'h0008, RETLW = ir[13:10]==4'b1101.
REQ-016 On GOTO the block SHALL set PC<=ir[10:0] and ir_valid<=0 for the next slot (one bubble).
REQ-017 On CALL the block SHALL push pc_out+1 (mod 2048), set PC<=ir[10:0], and insert one bubble.
REQ-018 On RETURN/RETLW the block SHALL pop the top of stack into PC and insert one bubble; W handling is not part of this block.
REQ-019 The stack SHALL be a circular STACK_DEPTH-entry buffer with a pointer; a push at depth STACK_DEPTH SHALL overwrite the oldest entry, and a pop at depth 0 SHALL return the entry at the pointer and wrap.
REQ-020 When skip_req=1 with ir_valid=1 and stall=0, the next slot SHALL be ir_valid=0 and PC SHALL advance normally.
REQ-021 Priority SHALL be reset > stall > flow change (GOTO/CALL/RETURN/RETLW) > skip_req; skip_req SHALL be ignored when the current instruction is a flow change.
REQ-022 With stall=1, PC, ir_out, ir_valid, pc_out, the stack and stack_err SHALL hold, and skip_req SHALL be ignored.
REQ-023 A bubble slot (ir_valid=0) SHALL never push, pop, jump or honour skip_req.

Reset
REQ-024 When reset=1 at a clock edge, the block SHALL set PC=RESET_VECTOR, ir_out=14'h0000, ir_valid=0, pc_out=11'h000, stack pointer=0, depth=0 and stack_err=0.
REQ-025 Stack entry contents SHALL not be cleared on reset.
REQ-026 Reset SHALL take effect mid-jump or mid-stall, with the first valid instruction appearing one cycle after reset deasserts.

Configuration
REQ-027 With macro PROGRAM_FETCH_STACK_GUARD_EN defined, a push at depth==STACK_DEPTH or a pop at depth==0 SHALL set stack_err=1 until reset, while stack behaviour stays as in REQ-019.
REQ-028 Without PROGRAM_FETCH_STACK_GUARD_EN, stack_err SHALL be tied to 0 and no depth-guard logic SHALL be present.

Verification
REQ-029 ROM 0x000-0x00F = 3000,008D,3000,008D,3009,008D,... and 0x010=2800, reset then run -> ir_out sequence 3000@0, 008D@1, ... 2800@0x10, then one ir_valid=0 slot, then 3000@0x000.
REQ-030 0x000=2005 (CALL 5) and 0x005=0008 (RETURN) -> bubble, execution at 0x005, bubble, then pc_out=0x001; depth ends at 0.
REQ-031 skip_req=1 while ir_out=008D@0x003 -> slot for 0x004 has ir_valid=0, and 0x005 is valid.
REQ-032 stall=1 for 3 cycles at pc_out=0x006 -> all outputs are constant for 3 cycles, then 0x007 follows.
REQ-033 RESET_VECTOR=0x7FE with sequential code -> pc_out 0x7FE, 0x7FF, 0x000.
REQ-034 Nine nested CALLs -> stack_err=1 after the ninth with the guard macro, and 0 without it; nine RETURNs then revisit return addresses 2..9 with the oldest lost.
